// File: rtl/prog_counter_pkg.sv
// Shared constants and helpers for the programmable up/down counter.
package prog_counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  function automatic int max_width();
    return 256;
  endfunction

endpackage

// File: rtl/prog_counter_next.sv
// Combinational next-count for one enabled step, honouring direction, limit and wrap/saturate mode.
module prog_counter_next
  import prog_counter_pkg::*;
#(
  parameter int WIDTH = 128
) (
  input  logic [WIDTH-1:0] cur,
  input  logic             up,
  input  logic             sat_mode,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] nxt,
  output logic             wrapped
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // +1 only below the limit and -1 only above zero, so neither can overflow.
  always_comb begin
    nxt     = cur;
    wrapped = 1'b0;
    if (up == DIR_UP) begin
      if (cur < limit) begin
        nxt = cur + ONE;
      end else if (sat_mode == MODE_SAT) begin
        nxt = limit;
      end else begin
        nxt     = '0;
        wrapped = 1'b1;
      end
    end else begin
      if (cur != '0) begin
        nxt = cur - ONE;
      end else if (sat_mode == MODE_SAT) begin
        nxt = '0;
      end else begin
        nxt     = limit;
        wrapped = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prog_counter.sv
// Programmable up/down counter with run-time limit, wrap/saturate mode, load, wrap pulse and sticky compare flag.
module prog_counter
  import prog_counter_pkg::*;
#(
  parameter int          WIDTH       = 128,
  parameter logic [255:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             sat_mode,
  input  logic [WIDTH-1:0] limit,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] cmp_value,
  input  logic             cmp_clr,
  output logic [WIDTH-1:0] out,
  output logic             wrap,
  output logic             cmp_hit
);

  if (WIDTH < 2 || WIDTH > max_width()) begin : g_bad_width
    $error("prog_counter: WIDTH %0d outside 2..%0d", WIDTH, max_width());
  end

  if ((RESET_VALUE >> WIDTH) != '0) begin : g_bad_reset_value
    $error("prog_counter: RESET_VALUE does not fit in WIDTH bits");
  end

  localparam logic [WIDTH-1:0] RST_VAL = RESET_VALUE[WIDTH-1:0];

  logic [WIDTH-1:0] out_reg, out_next;
  logic             wrap_reg, wrap_next;
  logic             cmp_hit_reg, cmp_hit_next;
  logic [WIDTH-1:0] step_nxt;
  logic             step_wrapped;
  logic             produced;

  prog_counter_next #(
    .WIDTH(WIDTH)
  ) u_next (
    .cur     (out_reg),
    .up      (up),
    .sat_mode(sat_mode),
    .limit   (limit),
    .nxt     (step_nxt),
    .wrapped (step_wrapped)
  );

  always_comb begin
    out_next  = out_reg;
    wrap_next = 1'b0;
    produced  = 1'b0;
    if (load) begin
      out_next = load_value;
      produced = 1'b1;
    end else if (en) begin
      out_next  = step_nxt;
      wrap_next = step_wrapped;
      produced  = 1'b1;
    end
    // A fresh match wins over a same-cycle clear; a held value never re-arms the flag.
    cmp_hit_next = (produced && (out_next == cmp_value)) || (cmp_hit_reg && !cmp_clr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_reg     <= RST_VAL;
      wrap_reg    <= 1'b0;
      cmp_hit_reg <= 1'b0;
    end else begin
      out_reg     <= out_next;
      wrap_reg    <= wrap_next;
      cmp_hit_reg <= cmp_hit_next;
    end
  end

  assign out     = out_reg;
  assign wrap    = wrap_reg;
  assign cmp_hit = cmp_hit_reg;

endmodule

// File: tb/tb_prog_counter.sv
// Scoreboard bench for prog_counter at WIDTH=8: per-cycle expected state queued at drive time, checked after the edge.
module tb_prog_counter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0, en = 1'b0, up = 1'b1, sat_mode = 1'b0;
  logic         load = 1'b0, cmp_clr = 1'b0;
  logic [W-1:0] limit = 8'd255, load_value = '0, cmp_value = 8'd0;
  logic [W-1:0] out;
  logic         wrap, cmp_hit;

  typedef struct {
    logic [W-1:0] out;
    logic         wrap;
    logic         hit;
  } exp_t;

  exp_t         sb_q[$];
  logic [W-1:0] m_out = '0;
  logic         m_wrap = 1'b0, m_hit = 1'b0;
  int           check_cnt = 0, fail_cnt = 0, txn = 0;
  int           wrap_seen = 0, last_wrap_txn = -1;

  prog_counter #(.WIDTH(W), .RESET_VALUE(256'd0)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .up        (up),
    .sat_mode  (sat_mode),
    .limit     (limit),
    .load      (load),
    .load_value(load_value),
    .cmp_value (cmp_value),
    .cmp_clr   (cmp_clr),
    .out       (out),
    .wrap      (wrap),
    .cmp_hit   (cmp_hit)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference behaviour written straight from the counter's rules.
  task automatic model_step();
    logic [W-1:0] no;
    logic         nw, prod;
    if (reset) begin
      m_out = '0; m_wrap = 1'b0; m_hit = 1'b0;
    end else begin
      no = m_out; nw = 1'b0; prod = 1'b0;
      if (load) begin
        no = load_value; prod = 1'b1;
      end else if (en) begin
        prod = 1'b1;
        if (up) begin
          if (m_out < limit) no = m_out + 8'd1;
          else if (sat_mode) no = limit;
          else begin no = '0; nw = 1'b1; end
        end else begin
          if (m_out > 8'd0) no = m_out - 8'd1;
          else if (sat_mode) no = '0;
          else begin no = limit; nw = 1'b1; end
        end
      end
      if (prod && no == cmp_value) m_hit = 1'b1;
      else if (cmp_clr) m_hit = 1'b0;
      m_out = no; m_wrap = nw;
    end
  endtask

  // Inputs are already set (after a falling edge); push expectation, clock, pop and compare.
  task automatic cycle();
    exp_t e;
    model_step();
    sb_q.push_back('{out: m_out, wrap: m_wrap, hit: m_hit});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    txn++;
    $display("txn %0d rst=%0b ld=%0b en=%0b up=%0b sat=%0b lim=%0d out=%0d wrap=%0b hit=%0b",
             txn, reset, load, en, up, sat_mode, limit, out, wrap, cmp_hit);
    check_eq("out", 32'(out), 32'(e.out));
    check_eq("wrap", 32'(wrap), 32'(e.wrap));
    check_eq("cmp_hit", 32'(cmp_hit), 32'(e.hit));
    if (wrap) begin wrap_seen++; last_wrap_txn = txn; end
    @(negedge clk);
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load = 1'b1; load_value = v; cycle(); load = 1'b0;
  endtask

  initial begin
    int base;
    @(negedge clk);

    // Reset then free count over the full 8-bit range.
    reset = 1'b1; en = 1'b1; load = 1'b1; load_value = 8'd33;
    cycle(); cycle();
    check_eq("reset_out", 32'(out), 32'd0);
    reset = 1'b0; load = 1'b0; cmp_value = 8'd0; up = 1'b1; limit = 8'd255;
    wrap_seen = 0; base = txn;
    for (int i = 0; i < 300; i++) cycle();
    check_eq("free_wraps", 32'(wrap_seen), 32'd1);
    check_eq("free_wrap_cycle", 32'(last_wrap_txn - base), 32'd256);
    check_eq("free_end_out", 32'(out), 32'd44);

    // Modulus 10 in wrap mode, then a down step from zero.
    en = 1'b0; do_load(8'd0); en = 1'b1;
    limit = 8'd9; sat_mode = 1'b0; cmp_clr = 1'b1; wrap_seen = 0;
    for (int i = 0; i < 25; i++) cycle();
    cmp_clr = 1'b0;
    check_eq("mod_wraps", 32'(wrap_seen), 32'd2);
    do_load(8'd0);
    up = 1'b0; cycle();
    check_eq("down_wrap_out", 32'(out), 32'd9);
    check_eq("down_wrap_pulse", 32'(wrap), 32'd1);

    // Limit of zero: stays at zero, pulses every step.
    limit = 8'd0; up = 1'b1; wrap_seen = 0;
    for (int i = 0; i < 3; i++) cycle();
    check_eq("lim0_wraps", 32'(wrap_seen), 32'd3);

    // Saturate at limit 5 both ways.
    limit = 8'd5; sat_mode = 1'b1; do_load(8'd0); wrap_seen = 0;
    for (int i = 0; i < 10; i++) cycle();
    check_eq("sat_up_out", 32'(out), 32'd5);
    check_eq("sat_up_wraps", 32'(wrap_seen), 32'd0);
    up = 1'b0;
    for (int i = 0; i < 8; i++) cycle();
    check_eq("sat_dn_out", 32'(out), 32'd0);

    // Loaded value above the limit.
    limit = 8'd10; sat_mode = 1'b0; up = 1'b1;
    do_load(8'd200);
    check_eq("load_hi_out", 32'(out), 32'd200);
    cycle();
    check_eq("hi_wrap_out", 32'(out), 32'd0);
    do_load(8'd200); sat_mode = 1'b1; cycle();
    check_eq("hi_sat_out", 32'(out), 32'd10);
    do_load(8'd200); up = 1'b0; cycle();
    check_eq("hi_dn_out", 32'(out), 32'd199);

    // Sticky compare flag.
    sat_mode = 1'b0; up = 1'b1; limit = 8'd20; cmp_value = 8'd7;
    do_load(8'd0);
    cmp_clr = 1'b1; cycle(); cmp_clr = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
    check_eq("cmp_rise", 32'(cmp_hit), 32'd1);
    cycle();
    check_eq("cmp_sticky", 32'(cmp_hit), 32'd1);
    do_load(8'd6);
    cmp_clr = 1'b1; cycle();
    check_eq("cmp_set_beats_clr", 32'(cmp_hit), 32'd1);
    en = 1'b0; cycle(); cmp_clr = 1'b0;
    check_eq("cmp_cleared", 32'(cmp_hit), 32'd0);
    cycle();
    check_eq("cmp_hold_no_reset", 32'(cmp_hit), 32'd0);

    // Priority and reset in the middle of counting.
    reset = 1'b1; load = 1'b1; load_value = 8'd42; en = 1'b1; cycle();
    check_eq("prio_reset", 32'(out), 32'd0);
    reset = 1'b0; cycle(); load = 1'b0;
    check_eq("prio_load", 32'(out), 32'd42);
    limit = 8'd255; cmp_value = 8'd100; do_load(8'd99); cycle();
    check_eq("mid_hit", 32'(cmp_hit), 32'd1);
    reset = 1'b1; cycle(); reset = 1'b0;
    check_eq("mid_reset_out", 32'(out), 32'd0);
    check_eq("mid_reset_hit", 32'(cmp_hit), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
    $finish;
  end

endmodule
